// File: rtl/tree_sum_pkg.sv
// Shared width and depth rules for the tree-sum scheduler and its adder tree.
// Latency: none (package of constants and pure functions).
// Backpressure: not applicable.
package tree_sum_pkg;

   // Result width: one extra bit per tree level, so the sum of 2**n lanes cannot overflow.
   function automatic int sum_w(input int dw, input int n);
      return dw + n;
   endfunction

   // Requester index width.
   function automatic int id_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Result buffer depth: one slot per tree stage plus two of slack.
   function automatic int fifo_depth(input int n);
      return n + 2;
   endfunction

endpackage

// File: rtl/pipelined_tree_adder.sv
// Unsigned reduction of 2**N lanes through N registered pairwise-add levels.
// Latency: N cycles from in_vec to out_sum, one level per cycle.
// Backpressure: none; the tree advances every cycle, flow control lives upstream.
module pipelined_tree_adder
   import tree_sum_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8
)(
   input  logic                    clk,
   input  logic [(2**N)*DW-1:0]    in_vec,
   output logic [sum_w(DW, N)-1:0] out_sum
);

   for (genvar l = 0; l <= N; l++) begin : g_lvl
      localparam int W = DW + l;
      localparam int C = 2 ** (N - l);
      logic [C*W-1:0] v;

      if (l == 0) begin : g_in
         assign v = in_vec;
      end else begin : g_add
         // Pairwise add of the previous level into operands one bit wider.
         always_ff @(posedge clk) begin
            for (int i = 0; i < C; i++) begin
               v[i*W +: W] <= {1'b0, g_lvl[l-1].v[(2*i)*(W-1) +: W-1]}
                            + {1'b0, g_lvl[l-1].v[(2*i+1)*(W-1) +: W-1]};
            end
         end
      end
   end

   assign out_sum = g_lvl[N].v;

endmodule

// File: rtl/tree_sum_scheduler.sv
// Round-robin arbiter feeding a pipelined lane-sum tree, with tag pipeline and result FIFO.
// Latency: result visible on res_* N cycles after the transfer (FIFO falls through when empty).
// Backpressure: credits cover tree + FIFO; with no credit left no grant is issued, so nothing drops.
module tree_sum_scheduler
   import tree_sum_pkg::*;
#(
   parameter int N    = 4,
   parameter int DW   = 8,
   parameter int NREQ = 4
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ*(2**N)*DW-1:0]   req_data,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [id_w(NREQ)-1:0]       res_id,
   output logic [sum_w(DW, N)-1:0]     res_sum
);

   localparam int L     = 2 ** N;
   localparam int SW    = sum_w(DW, N);
   localparam int IW    = id_w(NREQ);
   localparam int DEPTH = fifo_depth(N);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);

   typedef struct packed {
      logic [IW-1:0] id;
      logic [SW-1:0] sum;
   } res_t;

   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic            win_vld;
   logic [CW-1:0]   credits;
   logic            xfer;
   logic [L*DW-1:0] grant_vec;
   logic [SW-1:0]   tree_sum;
   logic [N-1:0]    tag_vld;
   logic [IW-1:0]   tag_id [N];
   res_t            mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            fifo_empty;
   logic            pipe_vld;
   res_t            pipe_ent;
   res_t            head;
   logic            pop;
   logic            push;
   logic            fifo_pop;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = rr_ptr + IW'(k);
         if (!win_vld && req_valid[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // A grant needs a winner and a free credit; reset holds every ready low.
   assign xfer      = win_vld && (credits != '0) && rst_n;
   assign req_ready = xfer ? (NREQ'(1) << win_idx) : '0;
   assign grant_vec = req_data[int'(win_idx)*L*DW +: L*DW];

   // Pointer moves past the granted requester only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rr_ptr <= '0;
      else if (xfer) rr_ptr <= win_idx + IW'(1);
   end

   // Credits track free slots across tree and FIFO; transfer takes one, pop returns one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) credits <= CW'(DEPTH);
      else if (xfer && !pop) credits <= credits - CW'(1);
      else if (!xfer && pop) credits <= credits + CW'(1);
   end

   pipelined_tree_adder #(.N(N), .DW(DW)) u_tree (
      .clk     (clk),
      .in_vec  (grant_vec),
      .out_sum (tree_sum)
   );

   // Tag valid bits walk alongside the tree levels and are cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
      end else begin
         tag_vld[0] <= xfer;
         for (int i = 1; i < N; i++) tag_vld[i] <= tag_vld[i-1];
      end
   end

   // Tag ids are data and need no reset.
   always_ff @(posedge clk) begin
      tag_id[0] <= win_idx;
      for (int i = 1; i < N; i++) tag_id[i] <= tag_id[i-1];
   end

   assign pipe_vld     = tag_vld[N-1];
   assign pipe_ent.id  = tag_id[N-1];
   assign pipe_ent.sum = tree_sum;

   // Empty FIFO falls through so a fresh result is visible in the cycle it leaves the tree.
   assign fifo_empty = (cnt == '0);
   assign head       = fifo_empty ? pipe_ent : mem[rd_ptr];
   assign res_valid  = !fifo_empty || pipe_vld;
   assign res_id     = head.id;
   assign res_sum    = head.sum;
   assign pop        = res_valid && res_ready;
   assign push       = pipe_vld && !(fifo_empty && pop);
   assign fifo_pop   = pop && !fifo_empty;

   // FIFO storage is data only.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pipe_ent;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)     wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
         if (fifo_pop) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         if (push && !fifo_pop)      cnt <= cnt + CW'(1);
         else if (!push && fifo_pop) cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_tree_sum_scheduler.sv
// Self-checking bench: reset, round-robin table, latency/sum corners, credit stall, reset flush, random.
// Latency: checks results appear N cycles after each transfer.
// Backpressure: exercises res_ready stalls until credits run out.
module tb_tree_sum_scheduler;

   localparam int N = 4, DW = 8, NREQ = 4;
   localparam int L = 2 ** N, SW = DW + N, IW = 2, DEPTH = N + 2;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic [NREQ-1:0]         req_valid = '0;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ*L*DW-1:0]    req_data = '0;
   logic                    res_valid;
   logic                    res_ready = 1'b0;
   logic [IW-1:0]           res_id;
   logic [SW-1:0]           res_sum;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rr = 0;

   typedef struct { int id; int sum; int due; } rec_t;
   rec_t q[$];

   typedef struct {
      logic [3:0] valid;
      logic       rdy;
      logic [3:0] exp_ready;
      logic       exp_vld;
      int         exp_id;
      int         exp_sum;
   } vec_t;
   vec_t tbl [8];

   always #5 clk = ~clk;

   tree_sum_scheduler #(.N(N), .DW(DW), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_sum   (res_sum)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_lane(input int r, input int k, input int val);
      req_data[(r*L+k)*DW +: DW] = val[DW-1:0];
   endtask

   function automatic int lane_sum(input int r);
      int s = 0;
      for (int k = 0; k < L; k++) s += int'(req_data[(r*L+k)*DW +: DW]);
      return s;
   endfunction

   // Reference: outstanding results form an ordered queue bounded by DEPTH; each is due N cycles after its grant.
   task automatic model_step(input bit do_chk);
      int  g;
      bit  ev;
      g = -1;
      if (q.size() < DEPTH)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(rr+k)%NREQ]) g = (rr+k) % NREQ;
      ev = (q.size() > 0) && (q[0].due <= cyc);
      if (do_chk) begin
         chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
         chk("res_valid", res_valid, ev);
         if (ev) begin
            chk("res_id", res_id, q[0].id);
            chk("res_sum", res_sum, q[0].sum);
         end
      end
      if (ev && res_ready) void'(q.pop_front());
      if (g >= 0) begin
         q.push_back('{g, lane_sum(g), cyc + N});
         rr = (g + 1) % NREQ;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step(1'b1);
      advance();
   endtask

   task automatic single_shot(input string nm, input int r, input int exp_sum);
      int lat;
      lat = -1;
      req_valid = NREQ'(1) << r;
      res_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) chk({nm, "_grant"}, req_ready, 1 << r);
         if (res_valid && lat < 0) begin
            lat = c;
            chk({nm, "_sum"}, res_sum, exp_sum);
            chk({nm, "_id"}, res_id, r);
         end
         model_step(1'b1);
         advance();
         if (c == 0) req_valid = '0;
      end
      chk({nm, "_latency"}, lat, N);
   endtask

   initial begin
      int grants, pops, both;

      // Round-robin table: everyone valid, lanes of requester r all equal r+1.
      for (int i = 0; i < 8; i++) begin
         tbl[i].valid     = 4'hF;
         tbl[i].rdy       = 1'b1;
         tbl[i].exp_ready = 4'b0001 << (i % 4);
         tbl[i].exp_vld   = (i >= 4);
         tbl[i].exp_id    = i % 4;
         tbl[i].exp_sum   = 16 * ((i % 4) + 1);
      end

      for (int r = 0; r < NREQ; r++)
         for (int k = 0; k < L; k++) set_lane(r, k, r + 1);

      // Reset state.
      req_valid = 4'hF;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_credits", dut.credits, DEPTH);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         req_valid = tbl[i].valid;
         res_ready = tbl[i].rdy;
         @(negedge clk);
         chk("tbl_req_ready", req_ready, tbl[i].exp_ready);
         chk("tbl_res_valid", res_valid, tbl[i].exp_vld);
         if (tbl[i].exp_vld) begin
            chk("tbl_res_id", res_id, tbl[i].exp_id);
            chk("tbl_res_sum", res_sum, tbl[i].exp_sum);
         end
         model_step(1'b0);
         advance();
      end
      req_valid = '0;
      repeat (10) tick();

      // All lanes 0xFF from requester 2.
      for (int k = 0; k < L; k++) set_lane(2, k, 8'hFF);
      single_shot("ff", 2, 12'hFF0);

      // Lane k = k from requester 3.
      for (int k = 0; k < L; k++) set_lane(3, k, k);
      single_shot("ramp", 3, 120);

      // Credit exhaustion with downstream stalled.
      for (int i = 0; i < NREQ*L*DW/32; i++) req_data[i*32 +: 32] = $urandom();
      res_ready = 1'b0;
      req_valid = 4'b0001;
      grants = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (req_ready[0]) grants++;
         model_step(1'b1);
         advance();
      end
      chk("stall_grants", grants, DEPTH);
      chk("stall_credits", dut.credits, 0);

      res_ready = 1'b1;
      pops = 0;
      both = 0;
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clk);
         if (res_valid && res_ready) pops++;
         if (res_valid && res_ready && req_ready != '0) both = 1;
         model_step(1'b1);
         advance();
      end
      chk("drain_pops", pops, DEPTH);
      chk("pop_and_grant", both, 1);
      repeat (10) tick();
      req_valid = '0;
      repeat (10) tick();

      // Reset with results buffered and in flight.
      res_ready = 1'b0;
      req_valid = 4'b0010;
      repeat (5) tick();
      req_valid = 4'hF;
      rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_req_ready", req_ready, 0);
      q.delete();
      rr = 0;
      advance();
      advance();
      req_valid = '0;
      rst_n = 1'b1;
      #1;
      chk("postrst_credits", dut.credits, DEPTH);
      res_ready = 1'b1;
      repeat (10) tick();

      // Random traffic against the queue model.
      for (int c = 0; c < 400; c++) begin
         req_valid = NREQ'($urandom_range(0, 15));
         res_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ*L*DW/32; i++) req_data[i*32 +: 32] = $urandom();
         tick();
      end
      req_valid = '0;
      res_ready = 1'b1;
      repeat (12) tick();
      chk("final_empty", res_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tree_sum_scheduler.md
TREE_SUM_SCHEDULER -- requirements
Module: tree_sum_scheduler

Interface
REQ-001 SHALL have parameter N, default 4: log2 of vector lanes (2**N operands per request).
REQ-002 SHALL have parameter DW, default 8: unsigned operand width.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester vector valid.
REQ-007 SHALL have port req_ready, output, NREQ: per-requester grant/accept.
REQ-008 SHALL have port req_data, input, NREQ*(2**N)*DW: requester r occupies slice r; lane k of that slice is bits [k*DW +: DW].
REQ-009 SHALL have port res_valid, output, 1: result valid.
REQ-010 SHALL have port res_ready, input, 1: downstream accept.
REQ-011 SHALL have port res_id, output, log2(NREQ): index of the requester that owns the result.
REQ-012 SHALL have port res_sum, output, DW+N: unsigned sum of all 2**N lanes.

Function
REQ-013 SHALL treat a request as transferred in a cycle where req_valid[r] and req_ready[r] are both high; at most one req_ready bit SHALL be high per cycle.
REQ-014 SHALL drive req_ready[r] high only when req_valid[r] is high, r is the round-robin winner, and a credit is available.
REQ-015 SHALL pick the round-robin winner as the first requester with valid set, searching upward from pointer rr_ptr with wrap-around.
REQ-016 SHALL set rr_ptr to (granted index + 1) mod NREQ after each transfer, and SHALL leave rr_ptr unchanged in cycles with no transfer.
REQ-017 SHALL feed the granted vector into an N-stage pipelined adder tree; each tree level is one register stage, so the sum emerges N cycles after the transfer.
REQ-018 SHALL widen sums by 1 bit per level (level L width DW+L), so the result never overflows; all arithmetic SHALL be unsigned.
REQ-019 SHALL carry the granted index and a valid bit alongside the tree in a matching N-stage shift pipeline.
REQ-020 SHALL write every emerging valid result into a result FIFO of depth DEPTH = N+2.
REQ-021 SHALL present the FIFO head on res_valid, res_id, and res_sum, and SHALL pop the head on res_valid && res_ready.
REQ-022 SHALL keep a credit counter initialised to DEPTH, decremented on each transfer and incremented on each pop; it SHALL be unchanged when a transfer and a pop occur in the same cycle.
REQ-023 SHALL issue no grant when credits == 0; this guarantees the FIFO never overflows and pipeline contents are never dropped.
REQ-024 SHALL return results in grant order; results SHALL never be reordered.
REQ-025 SHALL accept back-to-back grants at 1 per cycle while credits > 0 and res_ready is held high.
REQ-026 SHALL keep res_id and res_sum stable while res_valid is high and res_ready is low.
REQ-027 SHALL update FIFO contents and count correctly when a push and a pop occur in the same cycle on a full FIFO.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force: rr_ptr=0, credits=DEPTH, FIFO empty, all pipeline valid bits 0, res_valid=0, req_ready=0.
REQ-029 SHALL discard in-flight and buffered results when reset is asserted mid-operation; no result SHALL appear after rst_n rises unless a new transfer has occurred.
REQ-030 SHALL not reset the datapath sum registers or FIFO data storage; only control state is reset.

Structure
REQ-031 SHALL place in a shared package (tree_sum_pkg): the width functions (sum width DW+N, id width log2(NREQ)) and the DEPTH = N+2 constant rule.
REQ-032 SHALL instantiate exactly one sub-module, pipelined_tree_adder (parameters N, DW; ports clk, in_vec, out_sum), holding the registered tree levels.
REQ-033 SHALL implement the arbiter, credit counter, tag pipeline, and FIFO in tree_sum_scheduler itself.

Verification (N=4, DW=8, NREQ=4, DEPTH=6)
REQ-034 SHALL cover: requester 2 alone, all 16 lanes = 8'hFF, res_ready=1 -> res_valid exactly 4 cycles after the transfer, res_sum=12'hFF0, res_id=2.
REQ-035 SHALL cover: all four requesters valid continuously, res_ready=1 -> grants in order 0,1,2,3,0,... at 1 per cycle; res_id follows the same sequence.
REQ-036 SHALL cover: res_ready=0, requester 0 always valid -> exactly 6 transfers, then req_ready stays 0; raising res_ready yields 6 results, then grants resume.
REQ-037 SHALL cover: FIFO full with res_ready=1 and requester valid -> a pop and a grant occur in the same cycle, credits stay 0 to 0+1-1, and no result is lost.
REQ-038 SHALL cover: rst_n pulsed low with 3 results in flight -> res_valid=0 immediately and credits=6 after release; no stale result appears.
REQ-039 SHALL cover: lanes k = k (0..15) from requester 3 -> res_sum=120, res_id=3.
